control_seq: RTL and testbench

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_pkg.sv | 40 ++++
 rtl/control_decode.sv | 101 ++++++++++
 rtl/control_seq.sv | 154 +++++++++++++++
 tb/tb_control_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Shared constants for the control sequencer: RISC-V opcodes,
//                funct7 patterns, ALU operation codes and the FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

    // Opcodes
    localparam logic [6:0] c_OPC_RTYPE   = 7'b0110011;
    localparam logic [6:0] c_OPC_ITYPE   = 7'b0010011;

    // funct7 patterns: base encoding and the SUB/SRA alternate
    localparam logic [6:0] c_F7_BASE     = 7'd0;
    localparam logic [6:0] c_F7_ALT      = 7'd32;

    // ALU operation codes
    localparam logic [3:0] c_ALU_AND     = 4'b0000;
    localparam logic [3:0] c_ALU_OR      = 4'b0001;
    localparam logic [3:0] c_ALU_ADD     = 4'b0010;
    localparam logic [3:0] c_ALU_SLL     = 4'b0011;
    localparam logic [3:0] c_ALU_SUB     = 4'b0100;
    localparam logic [3:0] c_ALU_SRL     = 4'b0101;
    localparam logic [3:0] c_ALU_MUL     = 4'b0110;
    localparam logic [3:0] c_ALU_XOR     = 4'b0111;
    localparam logic [3:0] c_ALU_SRA     = 4'b1000;
    localparam logic [3:0] c_ALU_ILLEGAL = 4'b1111;

    // Width of the MUL latency counter (MUL_LAT is at most 15)
    localparam int         c_MUL_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
//  Module      : control_decode
//  Description : Purely combinational instruction decoder producing the ALU
//                control bundle.
//  Ports       : i_instr         - 32-bit instruction word
//                o_alu_control   - ALU operation code (1111 when illegal)
//                o_regwrite      - register-file write enable
//                o_alu_src_imm   - second operand is the immediate
//                o_illegal       - instruction not decodable
//                o_is_mul        - legal R-type MUL (multi-cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module control_decode
    import control_pkg::*;
#(
    parameter int EN_ITYPE = 1,
    parameter int EN_SRA   = 1
) (
    input  logic [31:0] i_instr,
    output logic [3:0]  o_alu_control,
    output logic        o_regwrite,
    output logic        o_alu_src_imm,
    output logic        o_illegal,
    output logic        o_is_mul
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_f7_base;
    logic       w_f7_alt;
    logic       w_legal;
    logic       w_imm;
    logic       w_mul;
    logic [3:0] w_alu;
    logic       w_unused;

    assign w_opcode  = i_instr[6:0];
    assign w_funct3  = i_instr[14:12];
    assign w_f7_base = (i_instr[31:25] == c_F7_BASE);
    assign w_f7_alt  = (i_instr[31:25] == c_F7_ALT);
    // rd and the register/immediate fields do not affect the decode
    assign w_unused  = &{1'b0, i_instr[24:7]};

    always_comb begin
        w_legal = 1'b0;
        w_alu   = c_ALU_ILLEGAL;
        w_imm   = 1'b0;
        w_mul   = 1'b0;
        if (w_opcode == c_OPC_RTYPE) begin
            case (w_funct3)
                3'd0: begin
                    if (w_f7_base) begin
                        w_legal = 1'b1; w_alu = c_ALU_ADD;
                    end else if (w_f7_alt) begin
                        w_legal = 1'b1; w_alu = c_ALU_SUB;
                    end
                end
                3'd1: if (w_f7_base) begin w_legal = 1'b1; w_alu = c_ALU_SLL; end
                3'd2: if (w_f7_base) begin w_legal = 1'b1; w_alu = c_ALU_MUL; w_mul = 1'b1; end
                3'd4: if (w_f7_base) begin w_legal = 1'b1; w_alu = c_ALU_XOR; end
                3'd5: begin
                    if (w_f7_base) begin
                        w_legal = 1'b1; w_alu = c_ALU_SRL;
                    end else if (w_f7_alt && (EN_SRA != 0)) begin
                        w_legal = 1'b1; w_alu = c_ALU_SRA;
                    end
                end
                3'd6: if (w_f7_base) begin w_legal = 1'b1; w_alu = c_ALU_OR;  end
                3'd7: if (w_f7_base) begin w_legal = 1'b1; w_alu = c_ALU_AND; end
                default: ;
            endcase
        end else if ((w_opcode == c_OPC_ITYPE) && (EN_ITYPE != 0)) begin
            w_imm = 1'b1;
            // funct7 only qualifies the shift-immediates; elsewhere it is immediate data
            case (w_funct3)
                3'd0: begin w_legal = 1'b1; w_alu = c_ALU_ADD; end
                3'd4: begin w_legal = 1'b1; w_alu = c_ALU_XOR; end
                3'd6: begin w_legal = 1'b1; w_alu = c_ALU_OR;  end
                3'd7: begin w_legal = 1'b1; w_alu = c_ALU_AND; end
                3'd1: if (w_f7_base) begin w_legal = 1'b1; w_alu = c_ALU_SLL; end
                3'd5: begin
                    if (w_f7_base) begin
                        w_legal = 1'b1; w_alu = c_ALU_SRL;
                    end else if (w_f7_alt && (EN_SRA != 0)) begin
                        w_legal = 1'b1; w_alu = c_ALU_SRA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_alu_control = w_legal ? w_alu : c_ALU_ILLEGAL;
    assign o_regwrite    = w_legal;
    assign o_alu_src_imm = w_legal & w_imm;
    assign o_illegal     = ~w_legal;
    assign o_is_mul      = w_legal & w_mul;

endmodule
`default_nettype wire

// File: rtl/control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : control_seq
//  Description : Valid/ready instruction sequencer. Decodes an accepted
//                instruction into a registered control bundle, stretches MUL
//                by MUL_LAT cycles, holds the bundle until consumed and counts
//                completed output handshakes.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                in_valid/in_ready - instruction handshake, instr word
//                out_valid/out_ready - bundle handshake
//                alu_control, regwrite_control, alu_src_imm, rd, illegal
//                                  - registered control bundle
//                busy              - MUL in flight
//                retired           - saturating completed-handshake count
//  Revision    : 1.0 - initial release
// ============================================================================
module control_seq
    import control_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int EN_ITYPE = 1,
    parameter int EN_SRA   = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_control,
    output logic             regwrite_control,
    output logic             alu_src_imm,
    output logic [4:0]       rd,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam logic [c_MUL_CNT_W-1:0] c_MUL_LOAD  = c_MUL_CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0]       c_RET_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]       c_RET_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic                   c_MUL_MULTI = (MUL_LAT > 1);

    state_t                   r_state;
    logic [c_MUL_CNT_W-1:0]   r_cnt;
    logic                     r_armed;
    logic                     r_out_valid;
    logic                     r_busy;
    logic [3:0]               r_alu;
    logic                     r_regwrite;
    logic                     r_imm;
    logic [4:0]               r_rd;
    logic                     r_illegal;
    logic [CNT_W-1:0]         r_retired;

    logic [3:0]               w_alu;
    logic                     w_regwrite;
    logic                     w_imm;
    logic                     w_illegal;
    logic                     w_is_mul;
    logic                     w_accept;

    control_decode #(
        .EN_ITYPE (EN_ITYPE),
        .EN_SRA   (EN_SRA)
    ) u_decode (
        .i_instr       (instr),
        .o_alu_control (w_alu),
        .o_regwrite    (w_regwrite),
        .o_alu_src_imm (w_imm),
        .o_illegal     (w_illegal),
        .o_is_mul      (w_is_mul)
    );

    // r_armed stays low through the first edge after reset release so that
    // edge can never accept an instruction.
    assign in_ready = r_armed &&
                      ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && out_ready));
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_armed     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_alu       <= 4'b0000;
            r_regwrite  <= 1'b0;
            r_imm       <= 1'b0;
            r_rd        <= 5'd0;
            r_illegal   <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_armed <= 1'b1;

            if (r_out_valid && out_ready && (r_retired != c_RET_MAX)) begin
                r_retired <= r_retired + c_RET_ONE;
            end

            // Accept only happens in IDLE or in HOLD while the held bundle
            // is being consumed, so it takes priority over the state moves.
            if (w_accept) begin
                r_alu      <= w_alu;
                r_regwrite <= w_regwrite;
                r_imm      <= w_imm;
                r_rd       <= instr[11:7];
                r_illegal  <= w_illegal;
                if (w_is_mul && c_MUL_MULTI) begin
                    r_state     <= ST_MUL_WAIT;
                    r_cnt       <= c_MUL_LOAD;
                    r_busy      <= 1'b1;
                    r_out_valid <= 1'b0;
                end else begin
                    r_state     <= ST_HOLD;
                    r_out_valid <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_MUL_WAIT: begin
                        if (r_cnt == c_MUL_CNT_W'(1)) begin
                            r_state     <= ST_HOLD;
                            r_cnt       <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - c_MUL_CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (out_ready) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign busy             = r_busy;
    assign alu_control      = r_alu;
    assign regwrite_control = r_regwrite;
    assign alu_src_imm      = r_imm;
    assign rd               = r_rd;
    assign illegal          = r_illegal;
    assign retired          = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_seq
//  Description : Self-checking bench for control_seq (MUL_LAT=3, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_seq;

    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 2;
    localparam int RET_MAX = (1 << CNT_W) - 1;
    localparam int N_VEC   = 25;

    typedef struct packed {
        logic [3:0] alu;
        logic       rw;
        logic       imm;
        logic       ill;
        logic [4:0] rd;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        exp_t        e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      instr = 32'd0;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       alu_control;
    logic             regwrite_control;
    logic             alu_src_imm;
    logic [4:0]       rd;
    logic             illegal;
    logic             busy;
    logic [CNT_W-1:0] retired;

    exp_t exp_q[$];
    vec_t vecs[N_VEC];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_ret = 0;

    control_seq #(
        .MUL_LAT  (MUL_LAT),
        .EN_ITYPE (1),
        .EN_SRA   (1),
        .CNT_W    (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .instr            (instr),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .alu_control      (alu_control),
        .regwrite_control (regwrite_control),
        .alu_src_imm      (alu_src_imm),
        .rd               (rd),
        .illegal          (illegal),
        .busy             (busy),
        .retired          (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rdi, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rdi, opc};
    endfunction

    function automatic exp_t ex(input logic [3:0] alu, input logic rw, input logic imm,
                                input logic ill, input logic [4:0] rdi);
        exp_t e;
        e.alu = alu; e.rw = rw; e.imm = imm; e.ill = ill; e.rd = rdi;
        return e;
    endfunction

    function automatic exp_t exill(input logic [4:0] rdi);
        return ex(4'b1111, 1'b0, 1'b0, 1'b1, rdi);
    endfunction

    function automatic vec_t mv(input logic [31:0] ins, input exp_t e);
        vec_t v;
        v.ins = ins; v.e = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, evaluate both handshakes just before the
    // rising edge, then return at the following negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                        input exp_t e, output logic acc);
        exp_t got;
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        #2;
        acc = v && in_ready;
        if (out_valid && out_ready) begin
            chk("retired_count", 32'(retired), 32'(model_ret));
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("out_alu", 32'(alu_control), 32'(got.alu));
                chk("out_regwrite", 32'(regwrite_control), 32'(got.rw));
                chk("out_imm", 32'(alu_src_imm), 32'(got.imm));
                chk("out_illegal", 32'(illegal), 32'(got.ill));
                chk("out_rd", 32'(rd), 32'(got.rd));
            end
            if (model_ret < RET_MAX) model_ret++;
        end
        if (acc) exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [6:0] R = 7'h33;
    localparam logic [6:0] I = 7'h13;

    initial begin
        logic acc;
        int   n;

        vecs[0]  = mv(mk(7'd0,  3'd0, 5'd1,  R), ex(4'b0010, 1, 0, 0, 5'd1));
        vecs[1]  = mv(mk(7'd32, 3'd0, 5'd2,  R), ex(4'b0100, 1, 0, 0, 5'd2));
        vecs[2]  = mv(mk(7'd0,  3'd6, 5'd3,  R), ex(4'b0001, 1, 0, 0, 5'd3));
        vecs[3]  = mv(mk(7'd0,  3'd7, 5'd4,  R), ex(4'b0000, 1, 0, 0, 5'd4));
        vecs[4]  = mv(mk(7'd0,  3'd1, 5'd5,  R), ex(4'b0011, 1, 0, 0, 5'd5));
        vecs[5]  = mv(mk(7'd0,  3'd5, 5'd6,  R), ex(4'b0101, 1, 0, 0, 5'd6));
        vecs[6]  = mv(mk(7'd32, 3'd5, 5'd7,  R), ex(4'b1000, 1, 0, 0, 5'd7));
        vecs[7]  = mv(mk(7'd0,  3'd4, 5'd8,  R), ex(4'b0111, 1, 0, 0, 5'd8));
        vecs[8]  = mv(mk(7'd0,  3'd2, 5'd9,  R), ex(4'b0110, 1, 0, 0, 5'd9));
        vecs[9]  = mv(mk(7'd1,  3'd6, 5'd10, R), exill(5'd10));
        vecs[10] = mv(mk(7'd0,  3'd3, 5'd11, R), exill(5'd11));
        vecs[11] = mv(mk(7'd1,  3'd2, 5'd12, R), exill(5'd12));
        vecs[12] = mv(mk(7'd32, 3'd1, 5'd13, R), exill(5'd13));
        vecs[13] = mv(mk(7'h7F, 3'd0, 5'd14, I), ex(4'b0010, 1, 1, 0, 5'd14));
        vecs[14] = mv(mk(7'd5,  3'd6, 5'd15, I), ex(4'b0001, 1, 1, 0, 5'd15));
        vecs[15] = mv(mk(7'd0,  3'd7, 5'd16, I), ex(4'b0000, 1, 1, 0, 5'd16));
        vecs[16] = mv(mk(7'd0,  3'd4, 5'd17, I), ex(4'b0111, 1, 1, 0, 5'd17));
        vecs[17] = mv(mk(7'd0,  3'd1, 5'd18, I), ex(4'b0011, 1, 1, 0, 5'd18));
        vecs[18] = mv(mk(7'd32, 3'd1, 5'd19, I), exill(5'd19));
        vecs[19] = mv(mk(7'd0,  3'd5, 5'd20, I), ex(4'b0101, 1, 1, 0, 5'd20));
        vecs[20] = mv(mk(7'd32, 3'd5, 5'd21, I), ex(4'b1000, 1, 1, 0, 5'd21));
        vecs[21] = mv(mk(7'd1,  3'd5, 5'd22, I), exill(5'd22));
        vecs[22] = mv(mk(7'd0,  3'd2, 5'd23, I), exill(5'd23));
        vecs[23] = mv(mk(7'd0,  3'd0, 5'd24, 7'h03), exill(5'd24));
        vecs[24] = mv(mk(7'd0,  3'd0, 5'd25, 7'h37), exill(5'd25));

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_alu", 32'(alu_control), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_retired", 32'(retired), 0);

        // ---------------- first edge after release must not accept ----------------
        rst_n = 1'b1; in_valid = 1'b1; instr = mk(7'd0, 3'd0, 5'd5, R); out_ready = 1'b1;
        #2;
        chk("in_ready_first_edge", 32'(in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        chk("no_accept_first_edge", 32'(out_valid), 0);

        // ---------------- ADD x5 ----------------
        step(1, mk(7'd0, 3'd0, 5'd5, R), 1, ex(4'b0010, 1, 0, 0, 5'd5), acc);
        chk("add_accept", 32'(acc), 1);
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_alu", 32'(alu_control), 32'b0010);
        chk("add_regwrite", 32'(regwrite_control), 1);
        chk("add_rd", 32'(rd), 5);
        step(0, 0, 1, '0, acc);
        chk("add_retired", 32'(retired), 1);

        // ---------------- MUL latency ----------------
        step(1, mk(7'd0, 3'd2, 5'd9, R), 0, ex(4'b0110, 1, 0, 0, 5'd9), acc);
        chk("mul_accept", 32'(acc), 1);
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            chk("mul_busy", 32'(busy), 1);
            chk("mul_in_ready", 32'(in_ready), 0);
            chk("mul_out_valid_early", 32'(out_valid), 0);
            step(1, mk(7'd0, 3'd4, 5'd30, R), 0, ex(4'b0111, 1, 0, 0, 5'd30), acc);
        end
        chk("mul_out_valid", 32'(out_valid), 1);
        chk("mul_busy_done", 32'(busy), 0);
        chk("mul_alu", 32'(alu_control), 32'b0110);
        step(0, 0, 1, '0, acc);

        // ---------------- SRAI held, then back-to-back accept ----------------
        step(1, mk(7'd32, 3'd5, 5'd3, I), 0, ex(4'b1000, 1, 1, 0, 5'd3), acc);
        chk("srai_accept", 32'(acc), 1);
        for (int k = 0; k < 4; k++) begin
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_alu", 32'(alu_control), 32'b1000);
            chk("hold_imm", 32'(alu_src_imm), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            step(1, mk(7'd0, 3'd0, 5'd31, R), 0, ex(4'b0010, 1, 0, 0, 5'd31), acc);
        end
        step(1, mk(7'd0, 3'd4, 5'd7, R), 1, ex(4'b0111, 1, 0, 0, 5'd7), acc);
        chk("b2b_accept", 32'(acc), 1);
        chk("b2b_out_valid", 32'(out_valid), 1);
        chk("b2b_alu", 32'(alu_control), 32'b0111);
        step(0, 0, 1, '0, acc);

        // ---------------- reset during MUL_WAIT ----------------
        step(1, mk(7'd0, 3'd2, 5'd4, R), 0, ex(4'b0110, 1, 0, 0, 5'd4), acc);
        step(0, 0, 0, '0, acc);
        chk("pre_reset_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_bundle", 32'({alu_control, regwrite_control, alu_src_imm, rd, illegal}), 0);
        chk("midrst_retired", 32'(retired), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        exp_q.delete();
        model_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 1, '0, acc);
            chk("post_rst_no_valid", 32'(out_valid), 0);
        end

        // ---------------- decode table, back-to-back with out_ready=1 ----------------
        for (int i = 0; i < N_VEC; i++) begin
            n = 0;
            acc = 1'b0;
            while (!acc && n < 40) begin
                step(1, vecs[i].ins, 1, vecs[i].e, acc);
                n++;
            end
            if (!acc) chk("accept_timeout", 32'(i), 32'hFFFF_FFFF);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(0, 0, 1, '0, acc);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("retired_sat", 32'(retired), 32'(RET_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
